store_unit: RTL and testbench

Data-side store engine for the rv32i core: the write-direction counterpart of the instruction fetch path. Accepts one store (SB/SH/SW) at a time from execute over a valid/ready handshake, and drives the memory block's read and write ports. Sub-word stores use a read-modify-write sequence; aligned SW writes directly. Reports completion and misalignment/illegal-width errors back to execute.

---
 rtl/store_unit.sv | 148 ++++++++++++++
 tb/tb_store_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : store_unit
//  Description : Data-side store engine. Takes SB/SH/SW from execute and
//                drives memory, using read-modify-write for sub-word stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        store_valid,
   output logic        store_ready,
   input  logic [31:0] store_address,
   input  logic [31:0] store_value,
   input  logic [2:0]  store_funct3,
   output logic        store_done,
   output logic        store_error,
   output logic        memory_read_enable,
   output logic [31:0] memory_read_address,
   input  logic [31:0] memory_read_value,
   output logic        memory_write_enable,
   output logic [31:0] memory_write_address,
   output logic [31:0] memory_write_value
);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_latency_check
      $error("store_unit: READ_LATENCY must be in 1..4");
   end

   localparam logic [2:0] c_READ_LATENCY = 3'(READ_LATENCY);
   localparam logic [2:0] c_F3_SB        = 3'b000;
   localparam logic [2:0] c_F3_SH        = 3'b001;
   localparam logic [2:0] c_F3_SW        = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_address;
   logic [15:0] r_value;
   logic        r_is_byte;
   logic [31:0] r_write_word;
   logic [2:0]  r_count;

   logic        w_accept;
   logic        w_is_sb;
   logic        w_is_sh;
   logic        w_is_sw;
   logic        w_bad;
   logic [31:0] w_merged;

   assign w_accept = store_valid && (r_state == ST_IDLE);
   assign w_is_sb  = (store_funct3 == c_F3_SB);
   assign w_is_sh  = (store_funct3 == c_F3_SH);
   assign w_is_sw  = (store_funct3 == c_F3_SW);
   assign w_bad    = !(w_is_sb || w_is_sh || w_is_sw)
                   || (w_is_sh && store_address[0])
                   || (w_is_sw && (store_address[1:0] != 2'b00));

   // Splice the captured store data into the freshly read word.
   always_comb begin
      w_merged = memory_read_value;
      if (r_is_byte) begin
         case (r_address[1:0])
            2'd0:    w_merged[7:0]   = r_value[7:0];
            2'd1:    w_merged[15:8]  = r_value[7:0];
            2'd2:    w_merged[23:16] = r_value[7:0];
            default: w_merged[31:24] = r_value[7:0];
         endcase
      end else if (r_address[1]) begin
         w_merged[31:16] = r_value;
      end else begin
         w_merged[15:0] = r_value;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_bad)        w_next_state = ST_ERROR;
               else if (w_is_sw) w_next_state = ST_WRITE;
               else              w_next_state = ST_READ;
            end
         end
         ST_READ:  w_next_state = ST_WAIT;
         ST_WAIT:  if (r_count == 3'd1) w_next_state = ST_WRITE;
         ST_WRITE: w_next_state = ST_IDLE;
         ST_ERROR: w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_address    <= '0;
         r_value      <= '0;
         r_is_byte    <= 1'b0;
         r_write_word <= '0;
         r_count      <= '0;
      end else begin
         if (w_accept) begin
            r_address    <= store_address;
            r_value      <= store_value[15:0];
            r_is_byte    <= w_is_sb;
            r_write_word <= store_value;
         end
         if (r_state == ST_READ) begin
            r_count <= c_READ_LATENCY;
         end else if (r_state == ST_WAIT) begin
            r_count <= r_count - 3'd1;
            // Read data is valid only in the last wait cycle.
            if (r_count == 3'd1) begin
               r_write_word <= w_merged;
            end
         end
      end
   end

   assign store_ready          = (r_state == ST_IDLE);
   assign store_done           = (r_state == ST_WRITE) || (r_state == ST_ERROR);
   assign store_error          = (r_state == ST_ERROR);
   assign memory_read_enable   = (r_state == ST_READ);
   assign memory_read_address  = (r_state == ST_READ)  ? {r_address[31:2], 2'b00} : 32'd0;
   assign memory_write_enable  = (r_state == ST_WRITE);
   assign memory_write_address = (r_state == ST_WRITE) ? {r_address[31:2], 2'b00} : 32'd0;
   assign memory_write_value   = (r_state == ST_WRITE) ? r_write_word : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_store_unit
//  Description : Directed self-checking bench, READ_LATENCY 1 and 3 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_1, rst_3;
   logic        v1, rdy1, done1, err1, re1, we1;
   logic [31:0] a1, sv1, ra1, rv1, wa1, wv1;
   logic [2:0]  f1;
   logic        v3, rdy3, done3, err3, re3, we3;
   logic [31:0] a3, sv3, ra3, rv3, wa3, wv3;
   logic [2:0]  f3;

   logic [31:0] mem1, mem3;
   logic [3:0]  pipe1 = '0;
   logic [3:0]  pipe3 = '0;

   store_unit #(.READ_LATENCY(1)) dut_l1 (
      .clock(clk), .reset(rst_1), .store_valid(v1), .store_ready(rdy1),
      .store_address(a1), .store_value(sv1), .store_funct3(f1),
      .store_done(done1), .store_error(err1),
      .memory_read_enable(re1), .memory_read_address(ra1), .memory_read_value(rv1),
      .memory_write_enable(we1), .memory_write_address(wa1), .memory_write_value(wv1)
   );

   store_unit #(.READ_LATENCY(3)) dut_l3 (
      .clock(clk), .reset(rst_3), .store_valid(v3), .store_ready(rdy3),
      .store_address(a3), .store_value(sv3), .store_funct3(f3),
      .store_done(done3), .store_error(err3),
      .memory_read_enable(re3), .memory_read_address(ra3), .memory_read_value(rv3),
      .memory_write_enable(we3), .memory_write_address(wa3), .memory_write_value(wv3)
   );

   // Memory returns the word only in the exact data-valid cycle, garbage otherwise.
   always @(posedge clk) begin
      pipe1 <= {pipe1[2:0], re1};
      pipe3 <= {pipe3[2:0], re3};
   end
   assign rv1 = pipe1[0] ? mem1 : 32'hFFFF_FFFF;
   assign rv3 = pipe3[2] ? mem3 : 32'hFFFF_FFFF;

   int          wcnt1 = 0, rcnt1 = 0, wcnt3 = 0, dcnt3 = 0, overlap = 0;
   logic [31:0] log_a [0:15];
   logic [31:0] log_v [0:15];

   always @(posedge clk) begin
      if (we1) begin
         if (wcnt1 < 16) begin
            log_a[wcnt1] = wa1;
            log_v[wcnt1] = wv1;
         end
         wcnt1++;
      end
      if (re1)   rcnt1++;
      if (we3)   wcnt3++;
      if (done3) dcnt3++;
      if ((re1 && we1) || (re3 && we3)) overlap++;
   end

   int passed = 0, failed = 0, total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          base, rbase, dbase, idx;
      logic [31:0] e_addr [0:2];
      logic [2:0]  e_f3   [0:2];
      logic [31:0] b_addr [0:2];
      logic [31:0] b_val  [0:2];
      logic [2:0]  b_f3   [0:2];
      logic        take;

      rst_1 = 1'b1; rst_3 = 1'b1;
      v1 = 1'b0; a1 = '0; sv1 = '0; f1 = '0;
      v3 = 1'b0; a3 = '0; sv3 = '0; f3 = '0;
      mem1 = '0; mem3 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset ready",   32'(rdy1),  32'd1);
      check("reset done",    32'(done1), 32'd0);
      check("reset error",   32'(err1),  32'd0);
      check("reset re",      32'(re1),   32'd0);
      check("reset we",      32'(we1),   32'd0);
      check("reset raddr",   ra1,        32'd0);
      check("reset waddr",   wa1,        32'd0);
      check("reset wdata",   wv1,        32'd0);
      check("reset ready3",  32'(rdy3),  32'd1);
      rst_1 = 1'b0; rst_3 = 1'b0;
      tick();

      // SW aligned
      v1 = 1'b1; a1 = 32'h100; sv1 = 32'hDEADBEEF; f1 = 3'b010;
      tick();
      v1 = 1'b0;
      check("sw we",    32'(we1),   32'd1);
      check("sw waddr", wa1,        32'h100);
      check("sw wdata", wv1,        32'hDEADBEEF);
      check("sw re",    32'(re1),   32'd0);
      check("sw done",  32'(done1), 32'd1);
      check("sw err",   32'(err1),  32'd0);
      check("sw busy",  32'(rdy1),  32'd0);
      tick();
      check("sw ready", 32'(rdy1),  32'd1);
      check("sw we off",32'(we1),   32'd0);
      check("sw done off", 32'(done1), 32'd0);

      // SB lane 2, latency 1
      mem1 = 32'h11223344;
      v1 = 1'b1; a1 = 32'h206; sv1 = 32'h000000AA; f1 = 3'b000;
      tick();
      v1 = 1'b0;
      check("sb re",    32'(re1), 32'd1);
      check("sb raddr", ra1,      32'h204);
      check("sb we c1", 32'(we1), 32'd0);
      tick();
      check("sb re c2", 32'(re1), 32'd0);
      check("sb we c2", 32'(we1), 32'd0);
      tick();
      check("sb we",    32'(we1),   32'd1);
      check("sb waddr", wa1,        32'h204);
      check("sb wdata", wv1,        32'h11AA3344);
      check("sb done",  32'(done1), 32'd1);
      check("sb err",   32'(err1),  32'd0);
      tick();
      check("sb ready", 32'(rdy1),  32'd1);

      // SH upper half, latency 3
      mem3 = 32'h12345678;
      v3 = 1'b1; a3 = 32'h302; sv3 = 32'h0000BEEF; f3 = 3'b001;
      tick();
      v3 = 1'b0;
      check("sh re",    32'(re3), 32'd1);
      check("sh raddr", ra3,      32'h300);
      tick(); tick(); tick();
      check("sh we c4", 32'(we3),  32'd0);
      check("sh busy",  32'(rdy3), 32'd0);
      tick();
      check("sh we",    32'(we3),   32'd1);
      check("sh waddr", wa3,        32'h300);
      check("sh wdata", wv3,        32'hBEEF5678);
      check("sh done",  32'(done3), 32'd1);
      tick();
      check("sh ready", 32'(rdy3),  32'd1);

      // Misaligned and illegal encodings
      e_addr[0] = 32'h401; e_f3[0] = 3'b001;
      e_addr[1] = 32'h402; e_f3[1] = 3'b010;
      e_addr[2] = 32'h400; e_f3[2] = 3'b011;
      base = wcnt1; rbase = rcnt1;
      for (int i = 0; i < 3; i++) begin
         v1 = 1'b1; a1 = e_addr[i]; sv1 = 32'h5555AAAA; f1 = e_f3[i];
         tick();
         v1 = 1'b0;
         check($sformatf("err%0d done", i), 32'(done1), 32'd1);
         check($sformatf("err%0d err", i),  32'(err1),  32'd1);
         check($sformatf("err%0d re", i),   32'(re1),   32'd0);
         check($sformatf("err%0d we", i),   32'(we1),   32'd0);
         tick();
         check($sformatf("err%0d ready", i), 32'(rdy1),  32'd1);
         check($sformatf("err%0d done off", i), 32'(done1), 32'd0);
      end
      check("err no writes", 32'(wcnt1 - base), 32'd0);
      check("err no reads",  32'(rcnt1 - rbase), 32'd0);

      // Reset while waiting on read data
      base = wcnt3; dbase = dcnt3;
      v3 = 1'b1; a3 = 32'h500; sv3 = 32'h00000055; f3 = 3'b000;
      tick();
      v3 = 1'b0;
      tick();
      check("rst in wait", 32'(rdy3), 32'd0);
      rst_3 = 1'b1;
      #1;
      check("rst ready now", 32'(rdy3), 32'd1);
      check("rst we now",    32'(we3),  32'd0);
      tick();
      rst_3 = 1'b0;
      repeat (5) tick();
      check("rst no write", 32'(wcnt3 - base),  32'd0);
      check("rst no done",  32'(dcnt3 - dbase), 32'd0);
      v3 = 1'b1; a3 = 32'h504; sv3 = 32'hA5A5A5A5; f3 = 3'b010;
      tick();
      v3 = 1'b0;
      check("post rst we",    32'(we3),   32'd1);
      check("post rst waddr", wa3,        32'h504);
      check("post rst wdata", wv3,        32'hA5A5A5A5);
      check("post rst done",  32'(done3), 32'd1);
      tick();

      // Back-to-back with store_valid held high
      mem1 = 32'h11223344;
      b_addr[0] = 32'h600; b_val[0] = 32'h01020304; b_f3[0] = 3'b010;
      b_addr[1] = 32'h601; b_val[1] = 32'h00000077; b_f3[1] = 3'b000;
      b_addr[2] = 32'h608; b_val[2] = 32'hCAFEF00D; b_f3[2] = 3'b010;
      base = wcnt1;
      idx = 0;
      a1 = b_addr[0]; sv1 = b_val[0]; f1 = b_f3[0]; v1 = 1'b1;
      for (int c = 0; c < 40 && idx < 3; c++) begin
         take = rdy1;
         tick();
         if (take) begin
            idx++;
            if (idx < 3) begin
               a1 = b_addr[idx]; sv1 = b_val[idx]; f1 = b_f3[idx];
            end else begin
               v1 = 1'b0;
            end
         end
      end
      check("b2b accepted", 32'(idx), 32'd3);
      tick(); tick();
      check("b2b writes", 32'(wcnt1 - base), 32'd3);
      check("b2b w0 addr", log_a[base],     32'h600);
      check("b2b w0 data", log_v[base],     32'h01020304);
      check("b2b w1 addr", log_a[base + 1], 32'h600);
      check("b2b w1 data", log_v[base + 1], 32'h11227744);
      check("b2b w2 addr", log_a[base + 2], 32'h608);
      check("b2b w2 data", log_v[base + 2], 32'hCAFEF00D);
      check("no re/we overlap", 32'(overlap), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
